// File: rtl/m2_block_scheduler.sv
// m2_block_scheduler: IDCT-stage sequencer. Walks every 8x8 block (Y, U, V) and
// launches the fetch / compute-T / compute-S / write-back engines in the overlapped
// two-megastate pipeline. It tracks block coordinates only.
module m2_block_scheduler #(
  parameter int unsigned Y_BLK_COLS  = 40,
  parameter int unsigned UV_BLK_COLS = 20,
  parameter int unsigned BLK_ROWS    = 30
) (
  input  logic       CLOCK_50_I,
  input  logic       Reset,
  input  logic       M2_start,
  output logic       M2_done,
  output logic       busy,
  output logic       fetch_start,
  input  logic       fetch_done,
  output logic       ct_start,
  input  logic       ct_done,
  output logic       cs_start,
  input  logic       cs_done,
  output logic       write_start,
  input  logic       write_done,
  output logic [1:0] fetch_plane,
  output logic [5:0] fetch_col,
  output logic [4:0] fetch_row,
  output logic [1:0] write_plane,
  output logic [5:0] write_col,
  output logic [4:0] write_row
);

  localparam int unsigned N_BLK = BLK_ROWS * (Y_BLK_COLS + 2 * UV_BLK_COLS);
  localparam int unsigned CNT_W = $clog2(N_BLK + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_BLK);
  localparam logic [5:0] Y_COL_LAST  = 6'(Y_BLK_COLS - 1);
  localparam logic [5:0] UV_COL_LAST = 6'(UV_BLK_COLS - 1);
  localparam logic [4:0] ROW_LAST    = 5'(BLK_ROWS - 1);

  typedef struct packed {
    logic [1:0] plane;
    logic [5:0] col;
    logic [4:0] row;
  } coord_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LI_F,
    S_LI_CT,
    S_MEGA_A,
    S_MEGA_B,
    S_LO_CS,
    S_LO_W,
    S_DONE
  } state_t;

  // Column fastest, then row, then plane. The final block of V holds its value.
  function automatic coord_t next_coord(input coord_t c);
    coord_t     n;
    logic [5:0] col_last;
    n        = c;
    col_last = (c.plane == 2'd0) ? Y_COL_LAST : UV_COL_LAST;
    if (c.col != col_last) begin
      n.col = c.col + 6'd1;
    end else if (c.row != ROW_LAST) begin
      n.col = '0;
      n.row = c.row + 5'd1;
    end else if (c.plane != 2'd2) begin
      n.col   = '0;
      n.row   = '0;
      n.plane = c.plane + 2'd1;
    end
    return n;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic             r_issue;
  logic             w_next_issue;
  logic             r_lat_f;
  logic             r_lat_ct;
  logic             r_lat_cs;
  logic             r_lat_w;
  coord_t           r_fco;
  coord_t           r_wco;
  logic [CNT_W-1:0] r_fcnt;

  logic w_exp_f;
  logic w_exp_ct;
  logic w_exp_cs;
  logic w_exp_w;
  logic w_phase_end;
  logic w_frame_go;
  logic w_acc_f;
  logic w_acc_w;

  // State register plus the ISSUE flag marking the first cycle of every phase.
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_issue <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_issue <= w_next_issue;
    end
  end

  // Next-state, phase-completion and engine launch decode.
  always_comb begin
    w_next_state = r_state;
    w_next_issue = 1'b0;
    w_exp_f      = 1'b0;
    w_exp_ct     = 1'b0;
    w_exp_cs     = 1'b0;
    w_exp_w      = 1'b0;
    w_frame_go   = 1'b0;

    case (r_state)
      S_LI_F:   w_exp_f  = 1'b1;
      S_LI_CT:  w_exp_ct = 1'b1;
      S_MEGA_A: begin
        w_exp_cs = 1'b1;
        w_exp_f  = 1'b1;
      end
      S_MEGA_B: begin
        w_exp_ct = 1'b1;
        w_exp_w  = 1'b1;
      end
      S_LO_CS:  w_exp_cs = 1'b1;
      S_LO_W:   w_exp_w  = 1'b1;
      default:  ;
    endcase

    // A done counts if already latched or arriving now; ISSUE-cycle dones never count.
    w_phase_end = !r_issue && (w_exp_f || w_exp_ct || w_exp_cs || w_exp_w) &&
                  (!w_exp_f  || r_lat_f  || fetch_done) &&
                  (!w_exp_ct || r_lat_ct || ct_done)    &&
                  (!w_exp_cs || r_lat_cs || cs_done)    &&
                  (!w_exp_w  || r_lat_w  || write_done);

    w_acc_f = w_exp_f && !r_issue && fetch_done && !r_lat_f;
    w_acc_w = w_exp_w && !r_issue && write_done && !r_lat_w;

    case (r_state)
      S_IDLE: begin
        if (M2_start) begin
          w_frame_go   = 1'b1;
          w_next_state = S_LI_F;
          w_next_issue = 1'b1;
        end
      end
      S_LI_F: begin
        if (w_phase_end) begin
          w_next_state = S_LI_CT;
          w_next_issue = 1'b1;
        end
      end
      S_LI_CT: begin
        if (w_phase_end) begin
          w_next_state = (r_fcnt >= N_CNT) ? S_LO_CS : S_MEGA_A;
          w_next_issue = 1'b1;
        end
      end
      S_MEGA_A: begin
        if (w_phase_end) begin
          w_next_state = S_MEGA_B;
          w_next_issue = 1'b1;
        end
      end
      // Every block fetched means the write of block N-2 just finished.
      S_MEGA_B: begin
        if (w_phase_end) begin
          w_next_state = (r_fcnt >= N_CNT) ? S_LO_CS : S_MEGA_A;
          w_next_issue = 1'b1;
        end
      end
      S_LO_CS: begin
        if (w_phase_end) begin
          w_next_state = S_LO_W;
          w_next_issue = 1'b1;
        end
      end
      S_LO_W: begin
        if (w_phase_end) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase

    fetch_start = r_issue && w_exp_f;
    ct_start    = r_issue && w_exp_ct;
    cs_start    = r_issue && w_exp_cs;
    write_start = r_issue && w_exp_w;
    M2_done     = (r_state == S_DONE);
    busy        = (r_state != S_IDLE);
  end

  // Sticky done latches, block coordinates and the saturating fetched-block count.
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      r_lat_f  <= 1'b0;
      r_lat_ct <= 1'b0;
      r_lat_cs <= 1'b0;
      r_lat_w  <= 1'b0;
      r_fco    <= '0;
      r_wco    <= '0;
      r_fcnt   <= '0;
    end else begin
      if (w_frame_go || r_issue || w_phase_end) begin
        r_lat_f  <= 1'b0;
        r_lat_ct <= 1'b0;
        r_lat_cs <= 1'b0;
        r_lat_w  <= 1'b0;
      end else begin
        if (w_exp_f  && fetch_done) r_lat_f  <= 1'b1;
        if (w_exp_ct && ct_done)    r_lat_ct <= 1'b1;
        if (w_exp_cs && cs_done)    r_lat_cs <= 1'b1;
        if (w_exp_w  && write_done) r_lat_w  <= 1'b1;
      end

      if (w_frame_go) begin
        r_fco  <= '0;
        r_wco  <= '0;
        r_fcnt <= '0;
      end else begin
        if (w_acc_f) begin
          r_fco <= next_coord(r_fco);
          if (r_fcnt != N_CNT) r_fcnt <= r_fcnt + CNT_W'(1);
        end
        if (w_acc_w) r_wco <= next_coord(r_wco);
      end
    end
  end

  assign fetch_plane = r_fco.plane;
  assign fetch_col   = r_fco.col;
  assign fetch_row   = r_fco.row;
  assign write_plane = r_wco.plane;
  assign write_col   = r_wco.col;
  assign write_row   = r_wco.row;

endmodule
